// File: rtl/dm_pipe_if.sv
// Request/response bundle between the MEM stage and the multi-cycle data memory.
// The requester is the master; the memory is the slave.
interface dm_pipe_if #(
    parameter int ADDR_W = 12
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W+1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_sext;
    logic [31:0]       req_wdata;
    logic [31:0]       req_pc;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_exc;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_sext, req_wdata, req_pc,
        input  req_ready, rsp_valid, rsp_rdata, rsp_exc
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_sext, req_wdata, req_pc,
        output req_ready, rsp_valid, rsp_rdata, rsp_exc
    );
endinterface

// File: rtl/dm_pipe.sv
// Multi-cycle byte-addressed data memory with lane steering and load extension; response LAT cycles after accept.
// One request in flight: req_ready only in IDLE, so a held req_valid is accepted every LAT+1 cycles.
module dm_pipe #(
    parameter int ADDR_W = 12,
    parameter int LAT    = 2,
    parameter bit LOG_EN = 1
) (
    input  logic     clk,
    input  logic     reset,
    dm_pipe_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W+1:0] addr;
        logic [1:0]        size;
        logic              sext;
        logic [31:0]       wdata;
        logic [31:0]       pc;
    } req_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    req_t        req_q, req_in, cur_req;
    logic        accept, enter_resp;
    logic [31:0] mem [DEPTH];
    logic [31:0] old_word, steered, merged, load_val;
    logic [3:0]  be;
    logic        misaligned;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] rdata_q;
    logic        exc_q;

    assign req_in = '{we: bus.req_we, addr: bus.req_addr, size: bus.req_size,
                      sext: bus.req_sext, wdata: bus.req_wdata, pc: bus.req_pc};

    assign accept     = bus.req_valid && (state_q == IDLE);
    assign enter_resp = (state_d == RESP) && (state_q != RESP);
    // With LAT=1 the commit edge is the accept edge, so work from the live request.
    assign cur_req    = (state_q == IDLE) ? req_in : req_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bus.req_ready = (state_q == IDLE);
        bus.rsp_valid = (state_q == RESP);
        case (state_q)
            IDLE: if (accept) begin
                cnt_d   = 3'(LAT - 1);
                state_d = (LAT == 1) ? RESP : WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign old_word = mem[cur_req.addr[ADDR_W+1:2]];

    always_comb begin
        be         = 4'b1111;
        steered    = cur_req.wdata;
        misaligned = 1'b0;
        case (cur_req.size)
            2'd0: begin
                be      = 4'b0001 << cur_req.addr[1:0];
                steered = {4{cur_req.wdata[7:0]}};
            end
            2'd1: begin
                be         = 4'b0011 << {cur_req.addr[1], 1'b0};
                steered    = {2{cur_req.wdata[15:0]}};
                misaligned = cur_req.addr[0];
            end
            default: misaligned = (cur_req.addr[1:0] != 2'b00);
        endcase
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = be[i] ? steered[8*i +: 8] : old_word[8*i +: 8];
        end
    end

    assign byte_sel = 8'(old_word >> {cur_req.addr[1:0], 3'b000});
    assign half_sel = 16'(old_word >> {cur_req.addr[1], 4'b0000});

    always_comb begin
        case (cur_req.size)
            2'd0:    load_val = {{24{cur_req.sext & byte_sel[7]}}, byte_sel};
            2'd1:    load_val = {{16{cur_req.sext & half_sel[15]}}, half_sel};
            default: load_val = old_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            req_q   <= '0;
            rdata_q <= '0;
            exc_q   <= 1'b0;
        end else begin
            if (accept) req_q <= req_in;
            if (enter_resp) begin
                exc_q   <= misaligned;
                rdata_q <= (misaligned || cur_req.we) ? 32'h0 : load_val;
                if (cur_req.we && !misaligned) begin
                    mem[cur_req.addr[ADDR_W+1:2]] <= merged;
                    if (LOG_EN)
                        $display("%d@%h: *%h <= %h", $time, cur_req.pc,
                                 32'({cur_req.addr[ADDR_W+1:2], 2'b00}), merged);
                end
            end else begin
                rdata_q <= '0;
                exc_q   <= 1'b0;
            end
        end
    end

    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_exc   = exc_q;
endmodule
